// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped I/O port bank on the MEM-stage data bus.
// Decodes byte offsets 0x80..0xFC (addr[7]=1) into a debounced switch
// register, a sticky change flag, N_OUT general output ports and a
// programmable 7-segment hex driver.
module io_port_bank #(
  parameter int unsigned N_OUT      = 4,
  parameter int unsigned SW_W       = 10,
  parameter int unsigned LED_W      = 10,
  parameter int unsigned N_HEX      = 6,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic                 we,
  input  logic                 re,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic [SW_W-1:0]      io_in_sw,
  output logic [LED_W-1:0]     io_out_led,
  output logic [7*N_HEX-1:0]   io_out_hex,
  output logic                 sw_changed
);

  // Word offsets within the I/O window (addr[6:2]).
  localparam logic [4:0]  OFF_SW     = 5'd0;
  localparam logic [4:0]  OFF_STATUS = 5'd1;
  localparam int unsigned OFF_OUT0   = 2;
  localparam logic [4:0]  OFF_HEX    = 5'd16;

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  // ---------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------
  logic       sel_io;
  logic [4:0] off;
  logic       wr_en;
  logic       rd_en;
  logic       unused_addr_bits;

  assign sel_io           = addr[7];
  assign off              = addr[6:2];
  assign wr_en            = we & sel_io;
  assign rd_en            = re & sel_io;
  assign unused_addr_bits = ^{addr[31:8], addr[1:0]};

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  logic [31:0]      out_q [N_OUT];
  logic [31:0]      out_d [N_OUT];
  logic [3:0]       hexctrl_q, hexctrl_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [SW_W-1:0]  sync1_q, sync2_q, prev_q;
  logic [SW_W-1:0]  deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             accept;

  // ---------------------------------------------------------------
  // Output port and HEXCTRL write logic
  // ---------------------------------------------------------------
  // Each register loads wdata when a qualified write hits its offset.
  always_comb begin
    for (int unsigned k = 0; k < N_OUT; k++) begin
      out_d[k] = out_q[k];
      if (wr_en && (32'(off) == OFF_OUT0 + k)) begin
        out_d[k] = wdata;
      end
    end
    hexctrl_d = hexctrl_q;
    if (wr_en && (off == OFF_HEX)) begin
      hexctrl_d = wdata[3:0];
    end
  end

  // ---------------------------------------------------------------
  // Read mux (pre-write values, so same-cycle write+read returns old data)
  // ---------------------------------------------------------------
  logic [31:0] rd_val;

  // Select the addressed register's current value; unmapped reads give 0.
  always_comb begin
    rd_val = '0;
    if (off == OFF_SW) begin
      rd_val[SW_W-1:0] = deb_q;
    end else if (off == OFF_STATUS) begin
      rd_val[0] = flag_q;
    end else if (off == OFF_HEX) begin
      rd_val[3:0] = hexctrl_q;
    end
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (32'(off) == OFF_OUT0 + k) begin
        rd_val = out_q[k];
      end
    end
    rdata_d = rd_en ? rd_val : rdata_q;
  end

  // ---------------------------------------------------------------
  // Switch debounce
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] cnt_next;

  // Count consecutive cycles the synchronised value differs from the
  // debounced value without changing; accept it after DEB_CYCLES.
  always_comb begin
    deb_d    = deb_q;
    cnt_d    = cnt_q;
    cnt_next = cnt_q;
    accept   = 1'b0;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else begin
      if (sync2_q != prev_q) begin
        cnt_next = CNT_W'(1);
      end else begin
        cnt_next = cnt_q + 1'b1;
      end
      if (cnt_next == CNT_W'(DEB_CYCLES)) begin
        deb_d  = sync2_q;
        cnt_d  = '0;
        accept = 1'b1;
      end else begin
        cnt_d = cnt_next;
      end
    end
  end

  // Sticky change flag: a new acceptance beats a clearing STATUS read.
  always_comb begin
    flag_d = flag_q;
    if (accept) begin
      flag_d = 1'b1;
    end else if (rd_en && (off == OFF_STATUS)) begin
      flag_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------
  // Register update
  // ---------------------------------------------------------------
  // All architectural state, with synchronous reset taking priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < N_OUT; k++) begin
        out_q[k] <= '0;
      end
      hexctrl_q <= 4'h1;
      rdata_q   <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      deb_q     <= '0;
      cnt_q     <= '0;
      flag_q    <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < N_OUT; k++) begin
        out_q[k] <= out_d[k];
      end
      hexctrl_q <= hexctrl_d;
      rdata_q   <= rdata_d;
      sync1_q   <= io_in_sw;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      flag_q    <= flag_d;
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [31:0] hex_src;
  logic [2:0]  hex_sel;

  assign hex_sel = hexctrl_q[3:1];

  // Pick the hex source port (out-of-range select falls back to port 0)
  // and decode one nibble per digit, blanking everything when disabled.
  always_comb begin
    hex_src = out_q[0];
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (32'(hex_sel) == k) begin
        hex_src = out_q[k];
      end
    end
    io_out_hex = '1;
    if (hexctrl_q[0]) begin
      for (int unsigned i = 0; i < N_HEX; i++) begin
        io_out_hex[7*i +: 7] = seg7(hex_src[4*i +: 4]);
      end
    end
  end

  assign io_out_led = out_q[0][LED_W-1:0];
  assign rdata      = rdata_q;
  assign sw_changed = flag_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Testbench for io_port_bank: vector table, directed corner sequences
// and randomized traffic, all compared against a behavioural model.
module tb_io_port_bank;

  localparam int N_OUT = 4;
  localparam int SW_W  = 10;
  localparam int LED_W = 10;
  localparam int N_HEX = 6;
  localparam int DEB   = 4;

  localparam logic [41:0] HZ   = {6{7'h40}};
  localparam logic [41:0] HBL  = {6{7'h7F}};
  localparam logic [41:0] H3A5 = {7'h40, 7'h40, 7'h40, 7'h30, 7'h08, 7'h12};
  localparam logic [41:0] H876 = {7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
  localparam logic [41:0] H155 = {7'h40, 7'h40, 7'h40, 7'h79, 7'h12, 7'h12};

  logic               clock = 1'b0;
  logic               reset;
  logic [31:0]        addr;
  logic               we;
  logic               re;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic [SW_W-1:0]    sw;
  logic [LED_W-1:0]   led;
  logic [7*N_HEX-1:0] hex;
  logic               chg;

  always #5 clock = ~clock;

  io_port_bank #(
    .N_OUT(N_OUT), .SW_W(SW_W), .LED_W(LED_W), .N_HEX(N_HEX), .DEB_CYCLES(DEB)
  ) dut (
    .clock(clock), .reset(reset), .addr(addr), .we(we), .re(re),
    .wdata(wdata), .rdata(rdata), .io_in_sw(sw), .io_out_led(led),
    .io_out_hex(hex), .sw_changed(chg)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]     m_out [N_OUT];
  logic [3:0]      m_hc;
  logic [SW_W-1:0] m_deb;
  logic            m_flag;
  logic [31:0]     m_rd;
  logic [SW_W-1:0] m_pipe [$];
  logic [SW_W-1:0] m_hist [$];

  task automatic model_reset();
    for (int k = 0; k < N_OUT; k++) m_out[k] = '0;
    m_hc = 4'h1; m_deb = '0; m_flag = 1'b0; m_rd = '0;
    m_pipe.delete(); m_pipe.push_back('0); m_pipe.push_back('0);
    m_hist.delete();
  endtask

  function automatic int out_index(input logic [31:0] a);
    int b;
    b = {a[7:2], 2'b00};
    if (b >= 'h88 && b < 'h88 + 4 * N_OUT) return (b - 'h88) / 4;
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int b;
    logic [31:0] v;
    b = {a[7:2], 2'b00};
    v = '0;
    if (b == 'h80) v[SW_W-1:0] = m_deb;
    else if (b == 'h84) v[0] = m_flag;
    else if (b == 'hC0) v[3:0] = m_hc;
    else if (out_index(a) >= 0) v = m_out[out_index(a)];
    return v;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [SW_W-1:0] sync;
    bit acc;
    int b;
    if (reset) begin
      model_reset();
      return;
    end
    b = {addr[7:2], 2'b00};
    sync = m_pipe.pop_front();
    m_pipe.push_back(sw);
    m_hist.push_back(sync);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    acc = 0;
    if (sync != m_deb && m_hist.size() == DEB) begin
      acc = 1;
      foreach (m_hist[j]) if (m_hist[j] != sync) acc = 0;
    end
    if (re && addr[7]) m_rd = model_read(addr);
    if (acc) m_flag = 1'b1;
    else if (re && addr[7] && b == 'h84) m_flag = 1'b0;
    if (we && addr[7]) begin
      if (out_index(addr) >= 0) m_out[out_index(addr)] = wdata;
      if (b == 'hC0) m_hc = wdata[3:0];
    end
    if (acc) m_deb = sync;
  endtask

  function automatic string lit_segs(input int d);
    case (d)
      0: return "abcdef";   1: return "bc";      2: return "abdeg";  3: return "abcdg";
      4: return "bcfg";     5: return "acdfg";   6: return "acdefg"; 7: return "abc";
      8: return "abcdefg";  9: return "abcdfg";  10: return "abcefg"; 11: return "cdefg";
      12: return "adef";    13: return "bcdeg";  14: return "adefg"; default: return "aefg";
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    string s;
    logic [6:0] r;
    s = lit_segs(d);
    r = '1;
    for (int j = 0; j < s.len(); j++) r[int'(s[j]) - 97] = 1'b0;
    return r;
  endfunction

  function automatic logic [7*N_HEX-1:0] model_hex();
    logic [31:0] src;
    logic [7*N_HEX-1:0] h;
    int sel;
    sel = int'(m_hc[3:1]);
    src = (sel < N_OUT) ? m_out[sel] : m_out[0];
    h = '1;
    if (m_hc[0])
      for (int i = 0; i < N_HEX; i++) h[7*i +: 7] = seg_of(int'((src >> (4*i)) & 32'hF));
    return h;
  endfunction

  task automatic check_model();
    check("model.rdata", rdata, m_rd);
    check("model.led", led, m_out[0][LED_W-1:0]);
    check("model.hex", hex, model_hex());
    check("model.sw_changed", chg, m_flag);
  endtask

  task automatic drive(input bit r, input bit w, input bit rd, input logic [31:0] a, input logic [31:0] d);
    reset = r; we = w; re = rd; addr = a; wdata = d;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clock);
    #1;
    check_model();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit               rst;
    bit               w;
    bit               r;
    logic [31:0]      a;
    logic [31:0]      d;
    logic [31:0]      e_rd;
    logic [LED_W-1:0] e_led;
    logic [41:0]      e_hex;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input bit rst, input bit w, input bit r, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] erd,
                              input logic [LED_W-1:0] el, input logic [41:0] eh);
    vec_t v;
    v.rst = rst; v.w = w; v.r = r; v.a = a; v.d = d; v.e_rd = erd; v.e_led = el; v.e_hex = eh;
    return v;
  endfunction

  int hold;

  initial begin
    model_reset();
    sw = '0;
    drive(1, 0, 0, 0, 0);

    tbl[0]  = mk(1, 0, 0, 32'h00, 32'h0,        32'h0,   10'h0,   HZ);
    tbl[1]  = mk(1, 0, 0, 32'h00, 32'h0,        32'h0,   10'h0,   HZ);
    tbl[2]  = mk(1, 0, 0, 32'h00, 32'h0,        32'h0,   10'h0,   HZ);
    tbl[3]  = mk(0, 1, 0, 32'h88, 32'h3A5,      32'h0,   10'h3A5, H3A5);
    tbl[4]  = mk(0, 0, 1, 32'h88, 32'h0,        32'h3A5, 10'h3A5, H3A5);
    tbl[5]  = mk(0, 1, 0, 32'h94, 32'h12345678, 32'h3A5, 10'h3A5, H3A5);
    tbl[6]  = mk(0, 1, 0, 32'hC0, 32'h7,        32'h3A5, 10'h3A5, H876);
    tbl[7]  = mk(0, 1, 1, 32'hC0, 32'h6,        32'h7,   10'h3A5, HBL);
    tbl[8]  = mk(0, 0, 1, 32'hC0, 32'h0,        32'h6,   10'h3A5, HBL);
    tbl[9]  = mk(0, 1, 0, 32'hC0, 32'hFFFFFFFF, 32'h6,   10'h3A5, H3A5);
    tbl[10] = mk(0, 0, 1, 32'hC0, 32'h0,        32'hF,   10'h3A5, H3A5);
    tbl[11] = mk(0, 1, 1, 32'h08, 32'h0,        32'hF,   10'h3A5, H3A5);
    tbl[12] = mk(0, 0, 1, 32'h84, 32'h0,        32'h0,   10'h3A5, H3A5);
    tbl[13] = mk(0, 1, 1, 32'hA0, 32'hDEAD,     32'h0,   10'h3A5, H3A5);
    tbl[14] = mk(1, 1, 0, 32'h8C, 32'hFFFFFFFF, 32'h0,   10'h0,   HZ);
    tbl[15] = mk(0, 1, 0, 32'hABCD0088, 32'h155, 32'h0,  10'h155, H155);
    tbl[16] = mk(0, 0, 1, 32'h88, 32'h0,        32'h155, 10'h155, H155);
    tbl[17] = mk(0, 0, 1, 32'h8C, 32'h0,        32'h0,   10'h155, H155);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
      cycle();
      check($sformatf("tbl%0d.rdata", i), rdata, tbl[i].e_rd);
      check($sformatf("tbl%0d.led", i), led, tbl[i].e_led);
      check($sformatf("tbl%0d.hex", i), hex, tbl[i].e_hex);
      check($sformatf("tbl%0d.chg", i), chg, 0);
    end

    // Switch latency: accepted exactly 2+DEB edges after the raw change.
    sw = 10'h021;
    drive(0, 0, 0, 0, 0);
    for (int e = 1; e <= 2 + DEB; e++) begin
      cycle();
      check($sformatf("lat.chg.e%0d", e), chg, (e == 2 + DEB));
    end
    drive(0, 0, 1, 32'h80, 0); cycle();
    check("lat.sw", rdata, 32'h21);
    check("lat.chg_after_swread", chg, 1);
    drive(0, 0, 1, 32'h84, 0); cycle();
    check("status.read1", rdata, 32'h1);
    check("status.cleared", chg, 0);
    drive(0, 0, 1, 32'h84, 0); cycle();
    check("status.read2", rdata, 32'h0);

    // Acceptance on the same edge as a STATUS read: set wins.
    sw = 10'h0A5;
    drive(0, 0, 0, 0, 0);
    for (int e = 1; e < 2 + DEB; e++) begin
      cycle();
      check($sformatf("setwin.chg.e%0d", e), chg, 0);
    end
    drive(0, 0, 1, 32'h84, 0); cycle();
    check("setwin.rdata_old", rdata, 32'h0);
    check("setwin.flag_kept", chg, 1);
    drive(0, 0, 1, 32'h84, 0); cycle();
    check("setwin.rdata", rdata, 32'h1);
    check("setwin.cleared", chg, 0);

    // Bouncing input never reaches the debounced register.
    for (int c = 0; c < 20; c++) begin
      sw = ((c / 2) % 2 != 0) ? 10'h155 : 10'h2AA;
      drive(0, 0, 1, 32'h80, 0); cycle();
      check($sformatf("bounce.sw.c%0d", c), rdata, 32'h0A5);
      check($sformatf("bounce.chg.c%0d", c), chg, 0);
    end
    sw = 10'h3FF;
    drive(0, 0, 0, 0, 0);
    for (int e = 1; e <= 2 + DEB; e++) begin
      cycle();
      check($sformatf("settle.chg.e%0d", e), chg, (e == 2 + DEB));
    end
    drive(0, 0, 1, 32'h80, 0); cycle();
    check("settle.sw", rdata, 32'h3FF);
    drive(0, 0, 1, 32'h84, 0); cycle();

    // Reset mid-count restarts the full debounce latency.
    drive(0, 1, 0, 32'h8C, 32'hFFFFFFFF); cycle();
    sw = 10'h0F0;
    drive(0, 0, 1, 32'h8C, 0); cycle();
    check("midrst.out1_set", rdata, 32'hFFFFFFFF);
    drive(0, 0, 0, 0, 0); cycle(); cycle();
    drive(1, 0, 0, 0, 0); cycle();
    check("midrst.rdata", rdata, 0);
    check("midrst.chg", chg, 0);
    drive(0, 0, 1, 32'h8C, 0); cycle();
    check("midrst.out1", rdata, 0);
    check("midrst.chg.e1", chg, 0);
    drive(0, 0, 0, 0, 0);
    for (int e = 2; e <= 2 + DEB; e++) begin
      cycle();
      check($sformatf("midrst.chg.e%0d", e), chg, (e == 2 + DEB));
    end

    // Randomized traffic against the model.
    hold = 0;
    for (int n = 0; n < 500; n++) begin
      logic [31:0] a;
      int pick;
      if (hold == 0) begin
        sw = SW_W'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      a = $urandom;
      a[7] = ($urandom_range(0, 7) != 0);
      pick = $urandom_range(0, 9);
      case (pick)
        0: a[6:2] = 5'd0;
        1: a[6:2] = 5'd1;
        2, 3, 4, 5: a[6:2] = 5'(pick);
        6: a[6:2] = 5'd16;
        7: a[6:2] = 5'd6;
        default: ;
      endcase
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
            a, $urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
